pwm_multi_channel: RTL

Wishbone-programmable multi-channel PWM generator. It is the parametrised successor to the single-channel user-area PWM, and sits inside user_project_wrapper, driving the upper mprj_io pads. It adds the following over the single-channel block:
- NUM_CH independent duty channels sharing one period counter.
- Edge- or center-aligned mode.
- Prescaler.
- Per-channel polarity and enable.
- Glitch-free shadow-register updates.
- Period-wrap interrupt.

---
 rtl/pwm_multi_channel.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/pwm_multi_channel.sv
// Wishbone-programmable multi-channel PWM: one prescaled period counter shared by
// NUM_CH duty comparators, edge/center alignment, shadowed period/duty, wrap IRQ.
module pwm_multi_channel #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned PRESC_W   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    output logic [NUM_CH-1:0] pwm_o,
    output logic [NUM_CH-1:0] pwm_oeb,
    output logic              irq_o
);
    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

    logic [2:0]         ctrl_q, ctrl_d;
    logic [CNT_W-1:0]   period_q, period_d, period_act_q, period_act_d;
    logic [PRESC_W-1:0] presc_q, presc_d, presc_cnt_q, presc_cnt_d;
    logic               wrap_q, wrap_d;
    logic [CNT_W-1:0]   duty_q [NUM_CH];
    logic [CNT_W-1:0]   duty_d [NUM_CH];
    logic [CNT_W-1:0]   duty_act_q [NUM_CH];
    logic [CNT_W-1:0]   duty_act_d [NUM_CH];
    logic [NUM_CH-1:0]  pol_q, pol_d, chen_q, chen_d;
    logic [NUM_CH-1:0]  pwm_q, pwm_d, oeb_q, oeb_d;
    logic               center_act_q, center_act_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    dir_e               dir_q, dir_d;
    logic               ack_q, ack_d;
    logic [31:0]        dat_q, dat_d;

    logic        en, hit, acc, wr, tick, bnd;
    logic [5:0]  idx;
    logic [31:0] rdata;
    logic        unused_bits;

    assign en          = ctrl_q[0];
    assign idx         = wbs_adr_i[7:2];
    assign hit         = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign acc         = hit & ~ack_q;
    assign wr          = acc & wbs_we_i;
    assign unused_bits = ^{wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};

    always_comb begin
        rdata = '0;
        case (idx)
            6'd0:    rdata[2:0]         = ctrl_q;
            6'd1:    rdata[CNT_W-1:0]   = period_q;
            6'd2:    rdata[PRESC_W-1:0] = presc_q;
            6'd3:    rdata[0]           = wrap_q;
            6'd12:   rdata[NUM_CH-1:0]  = pol_q;
            6'd13:   rdata[NUM_CH-1:0]  = chen_q;
            default: ;
        endcase
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (idx == 6'(i + 4)) rdata[CNT_W-1:0] = duty_q[i];
        end
    end

    always_comb begin
        ack_d    = acc;
        dat_d    = acc ? rdata : '0;
        ctrl_d   = ctrl_q;
        period_d = period_q;
        presc_d  = presc_q;
        pol_d    = pol_q;
        chen_d   = chen_q;
        wrap_d   = wrap_q;
        for (int unsigned i = 0; i < NUM_CH; i++) duty_d[i] = duty_q[i];
        if (wr) begin
            case (idx)
                6'd0:    ctrl_d   = wbs_dat_i[2:0];
                6'd1:    period_d = wbs_dat_i[CNT_W-1:0];
                6'd2:    presc_d  = wbs_dat_i[PRESC_W-1:0];
                6'd3:    if (wbs_dat_i[0]) wrap_d = 1'b0;
                6'd12:   pol_d    = wbs_dat_i[NUM_CH-1:0];
                6'd13:   chen_d   = wbs_dat_i[NUM_CH-1:0];
                default: ;
            endcase
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (idx == 6'(i + 4)) duty_d[i] = wbs_dat_i[CNT_W-1:0];
            end
        end
        // A boundary on the same edge as a W1C keeps WRAP set.
        if (bnd) wrap_d = 1'b1;
    end

    // Boundary: edge mode on the wrap tick, center mode on the tick leaving 0 downward.
    always_comb begin
        tick        = en & (presc_cnt_q == presc_q);
        presc_cnt_d = (!en || tick) ? '0 : presc_cnt_q + 1'b1;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        bnd         = 1'b0;
        if (!en) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end else if (tick) begin
            if (period_act_q == '0) begin
                cnt_d = '0;
                dir_d = DIR_UP;
                bnd   = 1'b1;
            end else if (!center_act_q) begin
                dir_d = DIR_UP;
                if (cnt_q >= period_act_q) begin
                    cnt_d = '0;
                    bnd   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (dir_q == DIR_UP) begin
                if (cnt_q >= period_act_q) begin
                    dir_d = DIR_DOWN;
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (cnt_q == '0) begin
                dir_d = DIR_UP;
                cnt_d = CNT_W'(1);
                bnd   = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_comb begin
        period_act_d = period_act_q;
        center_act_d = center_act_q;
        for (int unsigned i = 0; i < NUM_CH; i++) duty_act_d[i] = duty_act_q[i];
        if (!en || bnd) begin
            period_act_d = period_q;
            center_act_d = ctrl_q[1];
            for (int unsigned i = 0; i < NUM_CH; i++) duty_act_d[i] = duty_q[i];
        end
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            pwm_d[i] = ((en & chen_q[i]) ? (cnt_q < duty_act_q[i]) : 1'b0) ^ pol_q[i];
        end
        oeb_d = ~chen_q;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl_q       <= '0;
            period_q     <= '0;
            period_act_q <= '0;
            presc_q      <= '0;
            presc_cnt_q  <= '0;
            wrap_q       <= 1'b0;
            pol_q        <= '0;
            chen_q       <= '0;
            pwm_q        <= '0;
            oeb_q        <= '1;
            center_act_q <= 1'b0;
            cnt_q        <= '0;
            dir_q        <= DIR_UP;
            ack_q        <= 1'b0;
            dat_q        <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                duty_q[i]     <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            ctrl_q       <= ctrl_d;
            period_q     <= period_d;
            period_act_q <= period_act_d;
            presc_q      <= presc_d;
            presc_cnt_q  <= presc_cnt_d;
            wrap_q       <= wrap_d;
            pol_q        <= pol_d;
            chen_q       <= chen_d;
            pwm_q        <= pwm_d;
            oeb_q        <= oeb_d;
            center_act_q <= center_act_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            ack_q        <= ack_d;
            dat_q        <= dat_d;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                duty_q[i]     <= duty_d[i];
                duty_act_q[i] <= duty_act_d[i];
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign pwm_o     = pwm_q;
    assign pwm_oeb   = oeb_q;
    assign irq_o     = wrap_q & ctrl_q[2];

endmodule
